// File: rtl/uart_boot_ctrl_pkg.sv
// Shared types and constants for the UART program loader.
package uart_boot_ctrl_pkg;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CHK  = 3'd2,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned WORD_BYTES = 4;

    // Big-endian byte accumulation: the newest byte lands in the low lane.
    function automatic logic [31:0] shift_in(input logic [31:0] acc, input logic [7:0] b);
        return {acc[23:0], b};
    endfunction

endpackage

// File: rtl/uart_boot_ctrl_if.sv
// Byte-stream, imem-write and CPU-read signals of the UART boot controller.
// master: the side feeding bytes and popping the FIFO; slave: the controller.
interface uart_boot_ctrl_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              boot_done;
    logic              boot_err;
    logic              cpu_rd_valid;
    logic [7:0]        cpu_rd_data;
    logic              cpu_rd_ack;
    logic              rx_overrun;

    modport master (
        output rx_valid, rx_data, cpu_rd_ack,
        input  imem_we, imem_addr, imem_wdata, boot_done, boot_err,
               cpu_rd_valid, cpu_rd_data, rx_overrun
    );

    modport slave (
        input  rx_valid, rx_data, cpu_rd_ack,
        output imem_we, imem_addr, imem_wdata, boot_done, boot_err,
               cpu_rd_valid, cpu_rd_data, rx_overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead byte FIFO with sticky overrun flag.
// A push into a full FIFO succeeds only if a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int unsigned LOG = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_overrun
);
    localparam int unsigned DEPTH = 1 << LOG;

    logic [7:0]   r_mem [DEPTH];
    logic [LOG-1:0] r_wr;
    logic [LOG-1:0] r_rd;
    logic [LOG:0] r_cnt;
    logic         r_overrun;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == (LOG+1)'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    assign w_wr    = i_push && (!w_full || w_pop);

    // Storage array, written on every accepted push.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointers, occupancy and overrun flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (i_push && w_full && !w_pop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_valid   = !w_empty;
    assign o_data    = w_empty ? '0 : r_mem[r_rd];
    assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_boot_ctrl.sv
// UART boot controller: loads a word-count header and big-endian words into imem,
// then hands every later byte to a show-ahead FIFO for the core.
// Optional feature: define CHECKSUM_EN to require a trailing 8-bit payload sum byte.
module uart_boot_ctrl
    import uart_boot_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned FIFO_LOG  = 4
) (
    input  logic             clk,
    input  logic             rstn,
    uart_boot_ctrl_if.slave  bus
);
    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_shift;
    logic [ADDR_W:0]   r_nwords;
    logic [ADDR_W:0]   r_widx;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
`ifdef CHECKSUM_EN
    logic [7:0]        r_sum;
`endif

    logic [31:0]       w_assembled;
    logic              w_hdr_last;
    logic              w_word_last;
    logic              w_last_word;
    logic              w_hdr_ovf;
    logic              w_hdr_zero;
    logic [ADDR_W-1:0] w_addr;
    logic              w_push;

    assign w_assembled = shift_in(r_shift, bus.rx_data);
    assign w_hdr_last  = (r_byte_idx == 2'(HDR_BYTES - 1));
    assign w_word_last = (r_byte_idx == 2'(WORD_BYTES - 1));
    assign w_last_word = ((r_widx + (ADDR_W+1)'(1)) == r_nwords);
    assign w_hdr_ovf   = ({1'b0, w_assembled} > CAPACITY);
    assign w_hdr_zero  = (w_assembled == '0);
    assign w_addr      = ADDR_W'(BASE_ADDR) + r_widx[ADDR_W-1:0];
    assign w_push      = bus.rx_valid && (r_state == S_RUN);

    // Loader state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_LEN;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode from the incoming byte stream.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LEN: begin
                if (bus.rx_valid && w_hdr_last) begin
                    if (w_hdr_ovf) begin
                        w_next = S_ERR;
                    end else if (w_hdr_zero) begin
`ifdef CHECKSUM_EN
                        w_next = S_CHK;
`else
                        w_next = S_RUN;
`endif
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bus.rx_valid && w_word_last && w_last_word) begin
`ifdef CHECKSUM_EN
                    w_next = S_CHK;
`else
                    w_next = S_RUN;
`endif
                end
            end
`ifdef CHECKSUM_EN
            S_CHK: begin
                if (bus.rx_valid) begin
                    w_next = (bus.rx_data == r_sum) ? S_RUN : S_ERR;
                end
            end
`endif
            default: w_next = r_state;
        endcase
    end

    // Byte shifter, word counters and registered imem write port.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_byte_idx   <= '0;
            r_shift      <= '0;
            r_nwords     <= '0;
            r_widx       <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
`ifdef CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            r_imem_we <= 1'b0;
            if (bus.rx_valid && (r_state == S_LEN || r_state == S_DATA)) begin
                r_shift    <= w_assembled;
                r_byte_idx <= r_byte_idx + 2'd1;
            end
            if (bus.rx_valid && r_state == S_LEN && w_hdr_last) begin
                r_nwords <= w_assembled[ADDR_W:0];
                r_widx   <= '0;
            end
            if (bus.rx_valid && r_state == S_DATA) begin
`ifdef CHECKSUM_EN
                r_sum <= r_sum + bus.rx_data;
`endif
                if (w_word_last) begin
                    r_imem_we    <= 1'b1;
                    r_imem_addr  <= w_addr;
                    r_imem_wdata <= w_assembled;
                    r_widx       <= r_widx + (ADDR_W+1)'(1);
                end
            end
        end
    end

    uart_rx_fifo #(
        .LOG (FIFO_LOG)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .i_push    (w_push),
        .i_data    (bus.rx_data),
        .i_pop     (bus.cpu_rd_ack),
        .o_data    (bus.cpu_rd_data),
        .o_valid   (bus.cpu_rd_valid),
        .o_overrun (bus.rx_overrun)
    );

    // Status flags are decoded straight from the state register, so they are
    // registered and change on the same edge the state does.
    assign bus.boot_done  = (r_state == S_RUN);
    assign bus.boot_err   = (r_state == S_ERR);
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Scoreboard bench for uart_boot_ctrl (works with or without CHECKSUM_EN).
module tb_uart_boot_ctrl;
    localparam int unsigned AW = 14;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    uart_boot_ctrl_if #(.ADDR_W(AW)) bus ();

    uart_boot_ctrl #(
        .ADDR_W    (AW),
        .BASE_ADDR (0),
        .FIFO_LOG  (4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [7:0]  exp_fifo[$];
    wr_t         mon_e;
    logic [7:0]  run_sum;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // imem write monitor: every strobe must match the next expected write.
    always @(posedge clk) begin
        #1;
        if (bus.imem_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                check_eq("imem_we_unexpected", 64'(bus.imem_we), 64'd0);
            end else begin
                mon_e = exp_wr.pop_front();
                check_eq("imem_addr", 64'(bus.imem_addr), 64'(mon_e.addr));
                check_eq("imem_wdata", 64'(bus.imem_wdata), 64'(mon_e.data));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send32(input logic [31:0] w, input bit payload);
        logic [7:0] b;
        for (int i = 3; i >= 0; i--) begin
            b = w[8*i +: 8];
            if (payload) run_sum = run_sum + b;
            send(b);
        end
    endtask

    task automatic send_sum();
`ifdef CHECKSUM_EN
        send(run_sum);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn    = 1'b1;
        run_sum = '0;
    endtask

    task automatic ack_one();
        check_eq("fifo_valid", 64'(bus.cpu_rd_valid), 64'd1);
        if (exp_fifo.size() != 0)
            check_eq("fifo_data", 64'(bus.cpu_rd_data), 64'(exp_fifo.pop_front()));
        bus.cpu_rd_ack = 1'b1;
        @(negedge clk);
        bus.cpu_rd_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.rx_valid   = 1'b0;
        bus.rx_data    = '0;
        bus.cpu_rd_ack = 1'b0;
        run_sum        = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_boot_done", 64'(bus.boot_done), 64'd0);
        check_eq("rst_boot_err", 64'(bus.boot_err), 64'd0);
        check_eq("rst_imem_we", 64'(bus.imem_we), 64'd0);
        check_eq("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
        check_eq("rst_imem_wdata", 64'(bus.imem_wdata), 64'd0);
        check_eq("rst_rd_valid", 64'(bus.cpu_rd_valid), 64'd0);
        check_eq("rst_rd_data", 64'(bus.cpu_rd_data), 64'd0);
        check_eq("rst_overrun", 64'(bus.rx_overrun), 64'd0);
        rstn = 1'b1;

        // Two-word load.
        exp_wr.push_back('{addr: 14'd0, data: 32'h12345678});
        exp_wr.push_back('{addr: 14'd1, data: 32'h9ABCDEF0});
        send32(32'd2, 1'b0);
        send32(32'h12345678, 1'b1);
        send32(32'h9ABCDEF0, 1'b1);
        send_sum();
        repeat (2) @(negedge clk);
        check_eq("load2_done", 64'(bus.boot_done), 64'd1);
        check_eq("load2_err", 64'(bus.boot_err), 64'd0);
        check_eq("load2_pending", 64'(exp_wr.size()), 64'd0);

        // Run phase: first push shows up one cycle later.
        check_eq("fifo_empty0", 64'(bus.cpu_rd_valid), 64'd0);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h00;
        exp_fifo.push_back(8'h00);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        check_eq("fifo_latency", 64'(bus.cpu_rd_valid), 64'd1);
        check_eq("fifo_head0", 64'(bus.cpu_rd_data), 64'h00);
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 16; i++) begin
            if (i < 16) exp_fifo.push_back(8'(i));
            send(8'(i));
        end
        check_eq("fifo_overrun", 64'(bus.rx_overrun), 64'd1);

        // Push and ack together while full: both happen.
        check_eq("full_head", 64'(bus.cpu_rd_data), 64'(exp_fifo.pop_front()));
        exp_fifo.push_back(8'hAA);
        bus.rx_valid   = 1'b1;
        bus.rx_data    = 8'hAA;
        bus.cpu_rd_ack = 1'b1;
        @(negedge clk);
        bus.rx_valid   = 1'b0;
        bus.cpu_rd_ack = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 16; k++) ack_one();
        check_eq("fifo_drained", 64'(bus.cpu_rd_valid), 64'd0);
        check_eq("fifo_model_empty", 64'(exp_fifo.size()), 64'd0);
        bus.cpu_rd_ack = 1'b1;
        @(negedge clk);
        bus.cpu_rd_ack = 1'b0;
        @(negedge clk);
        check_eq("ack_empty_valid", 64'(bus.cpu_rd_valid), 64'd0);
        check_eq("ack_empty_data", 64'(bus.cpu_rd_data), 64'd0);
        check_eq("overrun_sticky", 64'(bus.rx_overrun), 64'd1);

        // Header overflow.
        do_reset();
        check_eq("rst2_overrun", 64'(bus.rx_overrun), 64'd0);
        check_eq("rst2_done", 64'(bus.boot_done), 64'd0);
        send32(32'h00004001, 1'b0);
        check_eq("ovf_err", 64'(bus.boot_err), 64'd1);
        check_eq("ovf_done", 64'(bus.boot_done), 64'd0);
        send32(32'h01020304, 1'b0);
        send(8'h00);
        check_eq("ovf_err_hold", 64'(bus.boot_err), 64'd1);
        check_eq("ovf_done_hold", 64'(bus.boot_done), 64'd0);
        check_eq("ovf_no_fifo", 64'(bus.cpu_rd_valid), 64'd0);

        // Zero-length image.
        do_reset();
        check_eq("rst3_err", 64'(bus.boot_err), 64'd0);
        send32(32'd0, 1'b0);
`ifdef CHECKSUM_EN
        check_eq("zero_wait_chk", 64'(bus.boot_done), 64'd0);
`endif
        send_sum();
        check_eq("zero_done", 64'(bus.boot_done), 64'd1);
        check_eq("zero_err", 64'(bus.boot_err), 64'd0);

        // Reset in the middle of word 0, then a fresh load.
        do_reset();
        send32(32'd1, 1'b0);
        send(8'h11);
        send(8'h22);
        do_reset();
        check_eq("abort_err", 64'(bus.boot_err), 64'd0);
        check_eq("abort_done", 64'(bus.boot_done), 64'd0);
        exp_wr.push_back('{addr: 14'd0, data: 32'hCAFEBABE});
        send32(32'd1, 1'b0);
        send32(32'hCAFEBABE, 1'b1);
        send_sum();
        repeat (2) @(negedge clk);
        check_eq("reload_done", 64'(bus.boot_done), 64'd1);
        check_eq("reload_err", 64'(bus.boot_err), 64'd0);
        check_eq("reload_pending", 64'(exp_wr.size()), 64'd0);

`ifdef CHECKSUM_EN
        // Checksum match and mismatch on a single word.
        do_reset();
        exp_wr.push_back('{addr: 14'd0, data: 32'h01020304});
        send32(32'd1, 1'b0);
        send32(32'h01020304, 1'b1);
        send(run_sum);
        check_eq("chk_ok_done", 64'(bus.boot_done), 64'd1);
        check_eq("chk_ok_err", 64'(bus.boot_err), 64'd0);
        do_reset();
        exp_wr.push_back('{addr: 14'd0, data: 32'h01020304});
        send32(32'd1, 1'b0);
        send32(32'h01020304, 1'b1);
        send(run_sum + 8'd1);
        check_eq("chk_bad_err", 64'(bus.boot_err), 64'd1);
        check_eq("chk_bad_done", 64'(bus.boot_done), 64'd0);
        check_eq("chk_pending", 64'(exp_wr.size()), 64'd0);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
